// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the register-file read/write ports between two req/ack masters.
// Latency: req seen in IDLE -> ACCESS next cycle -> ack the cycle after; requesters wait on req until acked.
module regfile_port_arbiter #(
    parameter int word_size  = 8,
    parameter int index_size = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [index_size-1:0] m0_addr,
    input  logic [word_size-1:0]  m0_wdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [index_size-1:0] m1_addr,
    input  logic [word_size-1:0]  m1_wdata,
    output logic                  m1_ack,
    output logic [word_size-1:0]  rdata,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  rf_write_enable,
    output logic [index_size-1:0] rf_write_address,
    output logic [word_size-1:0]  rf_write_data,
    output logic [index_size-1:0] rf_read_address,
    input  logic [word_size-1:0]  rf_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    lat_we;
    logic [index_size-1:0]   lat_addr;
    logic [word_size-1:0]    lat_wdata;
    logic                    last_grant;
    logic                    grant_vld;
    logic                    grant_sel;

    // On a tie the master that was not served last wins.
    always_comb begin
        grant_vld = m0_req | m1_req;
        grant_sel = 1'b0;
        if (m0_req && m1_req) begin
            grant_sel = ~last_grant;
        end else if (m1_req) begin
            grant_sel = 1'b1;
        end
    end

    always_comb begin
        state_nxt        = state;
        busy             = 1'b0;
        rf_write_enable  = 1'b0;
        rf_write_address = lat_addr;
        rf_read_address  = lat_addr;
        rf_write_data    = lat_wdata;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                busy            = 1'b1;
                rf_write_enable = lat_we;
                state_nxt       = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            grant_id   <= 1'b1;
            last_grant <= 1'b1;
            rdata      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
        end else begin
            state  <= state_nxt;
            m0_ack <= (state == ACCESS) && !grant_id;
            m1_ack <= (state == ACCESS) && grant_id;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        grant_id  <= grant_sel;
                        lat_we    <= grant_sel ? m1_we    : m0_we;
                        lat_addr  <= grant_sel ? m1_addr  : m0_addr;
                        lat_wdata <= grant_sel ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS: begin
                    // Writes leave the previous read result in place.
                    if (!lat_we) begin
                        rdata <= rf_read_data;
                    end
                end
                DONE: begin
                    last_grant <= grant_id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios plus two randomized masters, checked against
// a transaction-level model of arbitration order and register contents.
module tb_regfile_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0] m0_addr = '0;
    logic [7:0] m0_wdata = '0;
    logic       m0_ack;
    logic       m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0] m1_addr = '0;
    logic [7:0] m1_wdata = '0;
    logic       m1_ack;
    logic [7:0] rdata;
    logic       busy;
    logic       grant_id;
    logic       rf_write_enable;
    logic [3:0] rf_write_address;
    logic [7:0] rf_write_data;
    logic [3:0] rf_read_address;
    logic [7:0] rf_read_data;

    regfile_port_arbiter #(.word_size(8), .index_size(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .busy(busy), .grant_id(grant_id),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data), .rf_read_address(rf_read_address),
        .rf_read_data(rf_read_data)
    );

    always #5 clk = ~clk;

    // Register file attached to the arbiter; not cleared by reset.
    logic [7:0] rf_mem [16];
    bit         rf_seeded = 1'b0;
    always @(posedge clk) begin
        if (!rf_seeded) begin
            for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 37 + 11);
            rf_seeded = 1'b1;
        end else if (rf_write_enable) begin
            rf_mem[rf_write_address] = rf_write_data;
        end
    end
    assign rf_read_data = rf_mem[rf_read_address];

    int nchk = 0;
    int nerr = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Transaction each master is currently presenting (what the arbiter must act on).
    logic       t0_we, t1_we;
    logic [3:0] t0_addr, t1_addr;
    logic [7:0] t0_wdata, t1_wdata;

    // Reference model state.
    logic [7:0] exp_mem [16];
    bit         exp_seeded = 1'b0;
    logic       model_last = 1'b1;
    int         write_acks = 0;
    int         wen_cycles = 0;
    int         aborted = 0;
    int         cyc_n = 0;

    logic       h_r0 [1024];
    logic       h_r1 [1024];
    logic       h_busy [1024];
    logic       h_wen [1024];
    logic [3:0] h_wa [1024];
    logic [7:0] h_wd [1024];

    task automatic check_ack();
        logic [9:0] g;
        logic [9:0] a;
        logic       s;
        logic       exp_s;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        g = 10'(cyc_n - 2);
        a = 10'(cyc_n - 1);
        s = m1_ack;
        check_val("ack_onehot", 32'(m0_ack & m1_ack), 32'd0);
        exp_s = (h_r0[g] && h_r1[g]) ? ~model_last : ~h_r0[g];
        check_val("grant_order", 32'(s), 32'(exp_s));
        check_val("grant_id", 32'(grant_id), 32'(s));
        check_val("idle_at_grant", 32'(h_busy[g]), 32'd0);
        check_val("busy_in_access", 32'(h_busy[a]), 32'd1);
        check_val("busy_in_done", 32'(busy), 32'd1);
        we   = s ? t1_we : t0_we;
        addr = s ? t1_addr : t0_addr;
        data = s ? t1_wdata : t0_wdata;
        check_val("wen_in_access", 32'(h_wen[a]), 32'(we));
        if (we) begin
            check_val("write_addr", 32'(h_wa[a]), 32'(addr));
            check_val("write_data", 32'(h_wd[a]), 32'(data));
            exp_mem[addr] = data;
            write_acks++;
        end else begin
            check_val("read_data", 32'(rdata), 32'(exp_mem[addr]));
        end
        model_last = s;
    endtask

    always @(negedge clk) begin
        logic [9:0] k;
        if (!exp_seeded) begin
            for (int i = 0; i < 16; i++) exp_mem[i] = 8'(i * 37 + 11);
            exp_seeded = 1'b1;
        end
        if (!rst_n) begin
            model_last = 1'b1;
        end else begin
            cyc_n++;
            k = 10'(cyc_n);
            h_r0[k]   = m0_req;
            h_r1[k]   = m1_req;
            h_busy[k] = busy;
            h_wen[k]  = rf_write_enable;
            h_wa[k]   = rf_write_address;
            h_wd[k]   = rf_write_data;
            if (rf_write_enable) wen_cycles++;
            if (m0_ack || m1_ack) check_ack();
        end
    end

    task automatic start_txn(input bit m, input logic we, input logic [3:0] addr, input logic [7:0] d);
        if (!m) begin
            t0_we = we; t0_addr = addr; t0_wdata = d;
            m0_we = we; m0_addr = addr; m0_wdata = d; m0_req = 1'b1;
        end else begin
            t1_we = we; t1_addr = addr; t1_wdata = d;
            m1_we = we; m1_addr = addr; m1_wdata = d; m1_req = 1'b1;
        end
    endtask

    // Waits for the ack, then drops req at the edge that ends the ack cycle.
    task automatic finish_txn(input bit m, output logic [7:0] rd);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = m ? m1_ack : m0_ack;
        end
        rd = rdata;
        if (!got) check_val(m ? "m1_ack_timeout" : "m0_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!m) m0_req = 1'b0;
        else m1_req = 1'b0;
    endtask

    task automatic do_txn(input bit m, input logic we, input logic [3:0] addr, input logic [7:0] d,
                          output logic [7:0] rd);
        start_txn(m, we, addr, d);
        finish_txn(m, rd);
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = busy;
        end
        if (!seen) check_val("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] old4;
        logic [7:0] old6;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m0_ack", 32'(m0_ack), 32'd0);
        check_val("rst_m1_ack", 32'(m1_ack), 32'd0);
        check_val("rst_rdata", 32'(rdata), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wen", 32'(rf_write_enable), 32'd0);
        check_val("rst_grant_id", 32'(grant_id), 32'd1);
        rst_n = 1'b1;

        do_txn(1'b0, 1'b1, 4'd3, 8'hA5, rd);
        check_val("rf3_after_write", 32'(rf_mem[3]), 32'hA5);

        do_txn(1'b1, 1'b0, 4'd3, 8'h00, rd);
        check_val("m1_read3", 32'(rd), 32'hA5);

        fork
            begin
                repeat (4) do_txn(1'b0, 1'b1, 4'd1, 8'h11, rd);
            end
            begin
                logic [7:0] rd1;
                repeat (4) do_txn(1'b1, 1'b1, 4'd2, 8'h22, rd1);
            end
        join

        do_reset();
        fork
            begin
                logic [7:0] rd0;
                do_txn(1'b0, 1'b1, 4'd7, 8'h5C, rd0);
            end
            begin
                logic [7:0] rd1;
                do_txn(1'b1, 1'b0, 4'd7, 8'h00, rd1);
                check_val("m1_read7_after_m0", 32'(rd1), 32'h5C);
            end
        join

        old4 = exp_mem[4];
        start_txn(1'b0, 1'b1, 4'd4, 8'hFF);
        wait_busy();
        check_val("abort_wen_before", 32'(rf_write_enable), 32'd1);
        aborted++;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_wen_drop", 32'(rf_write_enable), 32'd0);
        check_val("abort_busy_drop", 32'(busy), 32'd0);
        check_val("abort_no_ack", 32'(m0_ack), 32'd0);
        m0_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("abort_rf4_kept", 32'(rf_mem[4]), 32'(old4));
        fork
            begin
                logic [7:0] rd0;
                do_txn(1'b0, 1'b0, 4'd4, 8'h00, rd0);
                check_val("abort_read4_old", 32'(rd0), 32'(old4));
            end
            begin
                logic [7:0] rd1;
                do_txn(1'b1, 1'b0, 4'd9, 8'h00, rd1);
            end
        join

        old6 = exp_mem[6];
        start_txn(1'b0, 1'b1, 4'd5, 8'h3C);
        wait_busy();
        #1;
        m0_addr = 4'd6;
        finish_txn(1'b0, rd);
        do_txn(1'b1, 1'b0, 4'd5, 8'h00, rd);
        check_val("latched_addr5", 32'(rd), 32'h3C);
        do_txn(1'b1, 1'b0, 4'd6, 8'h00, rd);
        check_val("addr6_untouched", 32'(rd), 32'(old6));

        fork
            begin
                logic [7:0] rd0;
                repeat (60) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    do_txn(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           8'($urandom_range(0, 255)), rd0);
                end
            end
            begin
                logic [7:0] rd1;
                repeat (60) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    do_txn(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                           8'($urandom_range(0, 255)), rd1);
                end
            end
        join

        repeat (3) @(posedge clk);
        #1;
        check_val("wen_cycle_count", 32'(wen_cycles), 32'(write_acks + aborted));
        for (int i = 0; i < 16; i++) check_val("final_rf", 32'(rf_mem[i]), 32'(exp_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
